morphologic_fitness_unit: RTL and testbench

Sequential fitness evaluator placed directly downstream of the morphologic processor. On `start`, it captures the accumulated result image and a target image. It then walks both images `ChunkWidth` pixels per cycle and reports three counts: matching pixels, false positives and false negatives. The genetic search engine uses `score` as the fitness of the individual (operator program) that produced the image.

---
 rtl/morphologic_fitness_unit_if.sv | 33 +++
 rtl/morphologic_fitness_unit.sv | 129 ++++++++++++
 tb/tb_morphologic_fitness_unit.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/morphologic_fitness_unit_if.sv
// rtl/morphologic_fitness_unit_if.sv - start/result bundle between the fitness unit and its host
// Optional mask signal present when MORPH_FITNESS_MASK_EN is defined.
interface morphologic_fitness_unit_if #(
   parameter int ImageWidth  = 8,
   parameter int ImageHeight = 8,
   parameter int ScoreWidth  = 7
);
   localparam int Pixels = ImageWidth * ImageHeight;

   logic                  start;
   logic [Pixels-1:0]     image;
   logic [Pixels-1:0]     target;
`ifdef MORPH_FITNESS_MASK_EN
   logic [Pixels-1:0]     mask;
`endif
   logic                  busy;
   logic                  done;
   logic [ScoreWidth-1:0] score;
   logic [ScoreWidth-1:0] falsePos;
   logic [ScoreWidth-1:0] falseNeg;

`ifdef MORPH_FITNESS_MASK_EN
   modport master (output start, image, target, mask,
                   input  busy, done, score, falsePos, falseNeg);
   modport slave  (input  start, image, target, mask,
                   output busy, done, score, falsePos, falseNeg);
`else
   modport master (output start, image, target,
                   input  busy, done, score, falsePos, falseNeg);
   modport slave  (input  start, image, target,
                   output busy, done, score, falsePos, falseNeg);
`endif
endinterface

// File: rtl/morphologic_fitness_unit.sv
// rtl/morphologic_fitness_unit.sv - chunked match / false-positive / false-negative counter for image fitness
// Optional care mask enabled by defining MORPH_FITNESS_MASK_EN.
module morphologic_fitness_unit #(
   parameter int ImageWidth  = 8,
   parameter int ImageHeight = 8,
   parameter int ChunkWidth  = 8,
   parameter int ScoreWidth  = 7
) (
   input logic clk,
   input logic rst,
   morphologic_fitness_unit_if.slave bus
);
   localparam int Pixels = ImageWidth * ImageHeight;
   localparam int N      = Pixels / ChunkWidth;
   localparam int CntW   = (N > 1) ? $clog2(N) : 1;
   localparam logic [CntW-1:0] LastChunk = CntW'(N - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t                state;
   logic [Pixels-1:0]     img_sr;
   logic [Pixels-1:0]     tgt_sr;
   logic [CntW-1:0]       chunk_cnt;
   logic [ScoreWidth-1:0] acc_match, acc_fp, acc_fn;
   logic [ScoreWidth-1:0] score_q, fp_q, fn_q;
   logic                  busy_q, done_q;

   logic [ChunkWidth-1:0] care;
   logic [ChunkWidth-1:0] match_bits, fp_bits, fn_bits;
   logic [ScoreWidth-1:0] c_match, c_fp, c_fn;

`ifdef MORPH_FITNESS_MASK_EN
   logic [Pixels-1:0]     msk_sr;
   assign care = msk_sr[ChunkWidth-1:0];
`else
   assign care = '1;
`endif

   assign match_bits = ~(img_sr[ChunkWidth-1:0] ^ tgt_sr[ChunkWidth-1:0]) & care;
   assign fp_bits    =   img_sr[ChunkWidth-1:0] & ~tgt_sr[ChunkWidth-1:0]  & care;
   assign fn_bits    =  ~img_sr[ChunkWidth-1:0] &  tgt_sr[ChunkWidth-1:0]  & care;

   // Popcount of the current chunk's classification bits
   always_comb begin
      c_match = '0;
      c_fp    = '0;
      c_fn    = '0;
      for (int i = 0; i < ChunkWidth; i++) begin
         c_match = c_match + ScoreWidth'(match_bits[i]);
         c_fp    = c_fp    + ScoreWidth'(fp_bits[i]);
         c_fn    = c_fn    + ScoreWidth'(fn_bits[i]);
      end
   end

   // Control FSM: load on start, walk the chunks, publish results and pulse done
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         img_sr    <= '0;
         tgt_sr    <= '0;
`ifdef MORPH_FITNESS_MASK_EN
         msk_sr    <= '0;
`endif
         chunk_cnt <= '0;
         acc_match <= '0;
         acc_fp    <= '0;
         acc_fn    <= '0;
         score_q   <= '0;
         fp_q      <= '0;
         fn_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  img_sr    <= bus.image;
                  tgt_sr    <= bus.target;
`ifdef MORPH_FITNESS_MASK_EN
                  msk_sr    <= bus.mask;
`endif
                  chunk_cnt <= '0;
                  acc_match <= '0;
                  acc_fp    <= '0;
                  acc_fn    <= '0;
                  busy_q    <= 1'b1;
                  state     <= BUSY;
               end
            end
            BUSY: begin
               acc_match <= acc_match + c_match;
               acc_fp    <= acc_fp + c_fp;
               acc_fn    <= acc_fn + c_fn;
               img_sr    <= img_sr >> ChunkWidth;
               tgt_sr    <= tgt_sr >> ChunkWidth;
`ifdef MORPH_FITNESS_MASK_EN
               msk_sr    <= msk_sr >> ChunkWidth;
`endif
               chunk_cnt <= chunk_cnt + 1'b1;
               if (chunk_cnt == LastChunk) begin
                  // Final chunk: publish sums including this chunk's contribution
                  score_q <= acc_match + c_match;
                  fp_q    <= acc_fp + c_fp;
                  fn_q    <= acc_fn + c_fn;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state   <= DONE;
               end
            end
            DONE: begin
               done_q <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               busy_q <= 1'b0;
               done_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.score    = score_q;
   assign bus.falsePos = fp_q;
   assign bus.falseNeg = fn_q;
endmodule

// File: tb/tb_morphologic_fitness_unit.sv
// tb/tb_morphologic_fitness_unit.sv - vector table, corner sequences and randomized model check of the fitness unit
module tb_morphologic_fitness_unit;
   localparam int W  = 8;
   localparam int H  = 8;
   localparam int CW = 8;
   localparam int SW = 7;
   localparam int P  = W * H;
   localparam int N  = P / CW;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   morphologic_fitness_unit_if #(.ImageWidth(W), .ImageHeight(H), .ScoreWidth(SW)) bus();

   morphologic_fitness_unit #(.ImageWidth(W), .ImageHeight(H), .ChunkWidth(CW), .ScoreWidth(SW)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int compared = 0;
   int mismatched = 0;
   int last_s = 0, last_fp = 0, last_fn = 0;

   typedef struct {
      string      nm;
      logic [P-1:0] img;
      logic [P-1:0] tgt;
      int         s;
      int         fp;
      int         fn;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string nm, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: classify every pixel independently, counting only cared-for pixels
   task automatic model(input logic [P-1:0] img, input logic [P-1:0] tgt, input logic [P-1:0] msk,
                        output int s, output int fp, output int fn);
      s = 0; fp = 0; fn = 0;
      for (int p = 0; p < P; p++) begin
         if (msk[p]) begin
            if (img[p] == tgt[p]) s++;
            else if (img[p]) fp++;
            else fn++;
         end
      end
   endtask

   task automatic set_mask(input logic [P-1:0] msk);
`ifdef MORPH_FITNESS_MASK_EN
      bus.mask = msk;
`else
      if (msk != msk) $display("unreachable");
`endif
   endtask

   // One full evaluation from an IDLE cycle; ends in the IDLE cycle after DONE
   task automatic run_eval(input string tag, input logic [P-1:0] img, input logic [P-1:0] tgt,
                           input logic [P-1:0] msk, input int es, input int efp, input int efn);
      int busy_cnt, done_cnt, done_at, overlap;
      bus.image = img;
      bus.target = tgt;
      set_mask(msk);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.image = {$urandom, $urandom};
      bus.target = {$urandom, $urandom};
      set_mask({$urandom, $urandom});
      chk({tag, " held score at start"}, int'(bus.score), last_s);
      busy_cnt = 0; done_cnt = 0; done_at = -1; overlap = 0;
      for (int k = 0; k <= N; k++) begin
         if (bus.busy) busy_cnt++;
         if (bus.done) begin done_cnt++; done_at = k; end
         if (bus.busy && bus.done) overlap++;
         if (k < N) tick();
      end
      chk({tag, " busy cycles"}, busy_cnt, N);
      chk({tag, " done latency"}, done_at, N);
      chk({tag, " done count"}, done_cnt, 1);
      chk({tag, " busy&done"}, overlap, 0);
      chk({tag, " score"}, int'(bus.score), es);
      chk({tag, " falsePos"}, int'(bus.falsePos), efp);
      chk({tag, " falseNeg"}, int'(bus.falseNeg), efn);
      tick();
      chk({tag, " done after pulse"}, int'(bus.done), 0);
      chk({tag, " score held"}, int'(bus.score), es);
      last_s = es; last_fp = efp; last_fn = efn;
   endtask

   initial begin
      logic [P-1:0] full;
      logic [P-1:0] ri, rt, rm;
      int s, fp, fn, done_cnt;
      full = '1;

      vecs[0] = '{"zeros",   64'h0,                   64'h0,                   64, 0,  0};
      vecs[1] = '{"ones_fp", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                   0,  64, 0};
      vecs[2] = '{"nibbles", 64'h0F,                  64'hF0,                  56, 4,  4};
      vecs[3] = '{"checker", 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 0,  32, 32};
      vecs[4] = '{"fn_top",  64'h0,                   64'h8000_0000_0000_0001, 62, 0,  2};

      bus.start = 1'b0;
      bus.image = '0;
      bus.target = '0;
      set_mask(full);
      rst = 1'b0;
      tick();
      tick();
      chk("reset busy", int'(bus.busy), 0);
      chk("reset done", int'(bus.done), 0);
      chk("reset score", int'(bus.score), 0);
      chk("reset falsePos", int'(bus.falsePos), 0);
      chk("reset falseNeg", int'(bus.falseNeg), 0);
      rst = 1'b1;
      tick();
      tick();
      chk("idle without start", int'(bus.busy), 0);

      for (int v = 0; v < 5; v++)
         run_eval(vecs[v].nm, vecs[v].img, vecs[v].tgt, full, vecs[v].s, vecs[v].fp, vecs[v].fn);

      // start during BUSY and DONE is ignored; next start lands once back in IDLE
      bus.image = 64'h0F;
      bus.target = 64'hF0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.image = '0;
      bus.target = '0;
      done_cnt = 0;
      for (int k = 1; k <= N; k++) begin
         tick();
         if (k == 2) bus.start = 1'b1;
         if (k == 3) bus.start = 1'b0;
         if (bus.done) done_cnt++;
      end
      chk("ignore done", int'(bus.done), 1);
      chk("ignore score", int'(bus.score), 56);
      chk("ignore falsePos", int'(bus.falsePos), 4);
      chk("ignore falseNeg", int'(bus.falseNeg), 4);
      bus.start = 1'b1;
      tick();
      if (bus.done) done_cnt++;
      chk("ignore single done", done_cnt, 1);
      chk("busy in DONE cycle+1", int'(bus.busy), 0);
      tick();
      chk("second start accepted", int'(bus.busy), 1);
      bus.start = 1'b0;
      for (int k = 1; k <= N; k++) tick();
      chk("second done", int'(bus.done), 1);
      chk("second score", int'(bus.score), 64);
      chk("second falsePos", int'(bus.falsePos), 0);
      chk("second falseNeg", int'(bus.falseNeg), 0);
      tick();
      last_s = 64; last_fp = 0; last_fn = 0;

      // Reset mid-BUSY aborts with no done pulse
      bus.image = 64'hFFFF_FFFF_FFFF_FFFF;
      bus.target = '0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int k = 1; k <= 4; k++) tick();
      rst = 1'b0;
      tick();
      chk("abort busy", int'(bus.busy), 0);
      chk("abort done", int'(bus.done), 0);
      chk("abort score", int'(bus.score), 0);
      chk("abort falsePos", int'(bus.falsePos), 0);
      chk("abort falseNeg", int'(bus.falseNeg), 0);
      rst = 1'b1;
      done_cnt = 0;
      for (int k = 0; k < N + 3; k++) begin
         tick();
         if (bus.done || bus.busy) done_cnt++;
      end
      chk("abort no activity", done_cnt, 0);
      last_s = 0; last_fp = 0; last_fn = 0;
      run_eval("after abort", 64'h0F, 64'hF0, full, 56, 4, 4);

`ifdef MORPH_FITNESS_MASK_EN
      run_eval("mask", 64'hFFFF_FFFF_FFFF_FF0F, 64'h0, 64'hFF, 4, 4, 0);
`endif

      for (int r = 0; r < 20; r++) begin
         ri = {$urandom, $urandom};
         rt = (r % 4 == 0) ? ri ^ P'({$urandom}) : {$urandom, $urandom};
`ifdef MORPH_FITNESS_MASK_EN
         rm = {$urandom, $urandom};
`else
         rm = full;
`endif
         model(ri, rt, rm, s, fp, fn);
         run_eval($sformatf("rand%0d", r), ri, rt, rm, s, fp, fn);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
